process_scheduler: RTL and testbench
====================================

# process_scheduler

Round-robin preemptive scheduler for the multi-program MIPS core: holds a per-process context table (alive flag, saved relative PC), generates the running process's base Offset, counts the time quantum, and forces a return to the OS on expiry or halt. Replaces the single-program quantum timer and fixed offset adder next to the Program_Counter. It is generalised to NUM_PROC slots, parametrised widths, and stall-aware quantum counting.

## Interface
- NUM_PROC, 4: process slots; power of two, ≥2.
- PC_WIDTH, 32: PC and offset width.
- Q_WIDTH, 16: quantum counter width.
- SLOT_SIZE, 256: instruction-memory words per process. Offset = index*SLOT_SIZE.
- IDX_W, $clog2(NUM_PROC): derived index width.

Ports:
- Clock  in  1  system clock (sys_clock); all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Register_Proc  in  1  in IDLE only: set alive[Proc_Index], clear saved_pc[Proc_Index].
- Start  in  1  in IDLE only: dispatch Proc_Index.
- Proc_Index  in  IDX_W  target slot for Register_Proc/Start.
- Quantum_Load  in  Q_WIDTH  quantum length, sampled on Start. 0 disables preemption.
- Input_Wait  in  1  core is stalled waiting for input; freezes the quantum counter.
- Halt_Proc  in  1  running program executed halt.
- PC_In  in  PC_WIDTH  current absolute PC.
- Running  out  1  a user process owns the core.
- Current_Proc  out  IDX_W  running or last-run slot.
- Offset  out  PC_WIDTH  base of Current_Proc while Running, else 0.
- Resume_PC  out  PC_WIDTH  saved_pc[Current_Proc], relative to the slot base.
- Preempt  out  1  one-cycle pulse on quantum expiry.
- Done  out  1  one-cycle pulse on halt.
- Next_Proc  out  IDX_W  next alive slot after Current_Proc, round-robin.
- Next_Valid  out  1  at least one slot is alive.
- Alive  out  NUM_PROC  alive bitmask.

## Operation
- FSM states: IDLE, RUN, EXPIRE, FINISH.
- **IDLE**
  - Register_Proc sets alive[Proc_Index]=1 and saved_pc[Proc_Index]=0.
  - Start with alive[Proc_Index]=1 enters RUN. It loads Current_Proc=Proc_Index and qcnt=Quantum_Load, and records qen = (Quantum_Load≠0).
  - Start on a dead slot is ignored.
  - If Register_Proc and Start arrive together, registration happens first, so the Start succeeds.
- **RUN**
  - qcnt decrements each cycle when qen=1 and Input_Wait=0.
  - If qcnt==1 and a decrement occurs, go to EXPIRE.
  - Halt_Proc goes to FINISH. Halt has priority over a same-cycle expiry.
  - Register_Proc and Start are ignored.
- **EXPIRE** (1 cycle): Preempt=1; saved_pc[Current_Proc] <= PC_In − Offset (mod 2^PC_WIDTH). Then IDLE.
- **FINISH** (1 cycle): Done=1; alive[Current_Proc] <= 0; saved_pc is cleared. Then IDLE.
- **Next_Proc** is combinational. It is the first alive slot scanning Current_Proc+1, +2, … and wrapping modulo NUM_PROC, with Current_Proc itself checked last. When Alive==0: Next_Valid=0 and Next_Proc=0.

## Timing
- Reset values:
  - State IDLE; Running=0; Current_Proc=0; Offset=0; Resume_PC=0.
  - Preempt=0; Done=0; Alive=0; all saved_pc=0; qcnt=0.
- Start latency: Running=1 and Offset valid in the cycle after the Start edge. Resume_PC is valid in the same cycle.
- Quantum Q with no stalls: Preempt is asserted exactly Q cycles after Running rises. Each stalled cycle adds one cycle.
- Running=0 from the cycle EXPIRE/FINISH is entered. Offset returns to 0 in that same cycle. PC_In − Offset is computed from the pre-transition Offset register.
- Reset asserted mid-RUN: immediate asynchronous return to reset values. No Preempt/Done pulse and no save.

## Configuration
- SCHED_ACCOUNTING_EN defined:
  - Adds per-slot 32-bit cycle counters, incremented in RUN for Current_Proc and saturating at 2^32−1.
  - Adds ports Stats_Sel (in, IDX_W) and Stats_Count (out, 32), combinational read.
  - Register_Proc clears the slot's counter.
- Undefined: no counters and no such ports; the rest is unchanged.

## Structure
- Shared package sched_pkg:
  - State enum: IDLE/RUN/EXPIRE/FINISH.
  - Default constants: NUM_PROC, SLOT_SIZE, Q_WIDTH.
- One sub-module, rr_next_alive: Alive mask + Current_Proc → Next_Proc, Next_Valid. Purely combinational, parametrised by NUM_PROC.

## Test plan
- Register slots 0 and 2; Start idx 2, Quantum_Load=5, no stalls, PC_In=0x205 at expiry → Offset=0x200 during RUN; Preempt 5 cycles after Running; saved_pc[2]=5; Next_Proc=0.
- Same run, Input_Wait high for 3 cycles mid-quantum → Preempt at cycle 8.
- Halt_Proc and expiry in the same cycle → Done=1, Preempt=0, Alive[2]=0, Next_Proc=0.
- Start idx 1 (unregistered) → stays IDLE, Running=0. Quantum_Load=0 → no Preempt within 1000 cycles; Halt then ends the run.
- Reset pulsed in RUN with qcnt=3 → all outputs at reset values within the same cycle; no pulses; Alive=0.
- With SCHED_ACCOUNTING_EN: a 5-cycle quantum on idx 2 → Stats_Count for idx 2 = 5; Register_Proc 2 → 0.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and default sizing for the round-robin process scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2,
    FINISH = 2'd3
  } sched_state_t;

  localparam int DEF_NUM_PROC  = 4;
  localparam int DEF_PC_WIDTH  = 32;
  localparam int DEF_Q_WIDTH   = 16;
  localparam int DEF_SLOT_SIZE = 256;

endpackage

// File: rtl/process_scheduler_if.sv
// Control/status bundle between the core/OS side and the process scheduler.
// Latency: n/a (wires only); Stats_* exist only when SCHED_ACCOUNTING_EN is defined.
// Backpressure: none; Input_Wait stalls quantum counting, nothing else.
interface process_scheduler_if #(
  parameter int NUM_PROC = 4,
  parameter int PC_WIDTH = 32,
  parameter int Q_WIDTH  = 16
);
  localparam int IDX_W = $clog2(NUM_PROC);

  logic                Register_Proc;
  logic                Start;
  logic [IDX_W-1:0]    Proc_Index;
  logic [Q_WIDTH-1:0]  Quantum_Load;
  logic                Input_Wait;
  logic                Halt_Proc;
  logic [PC_WIDTH-1:0] PC_In;
  logic                Running;
  logic [IDX_W-1:0]    Current_Proc;
  logic [PC_WIDTH-1:0] Offset;
  logic [PC_WIDTH-1:0] Resume_PC;
  logic                Preempt;
  logic                Done;
  logic [IDX_W-1:0]    Next_Proc;
  logic                Next_Valid;
  logic [NUM_PROC-1:0] Alive;
`ifdef SCHED_ACCOUNTING_EN
  logic [IDX_W-1:0]    Stats_Sel;
  logic [31:0]         Stats_Count;
`endif

  modport master (
    output Register_Proc, Start, Proc_Index, Quantum_Load, Input_Wait, Halt_Proc, PC_In,
`ifdef SCHED_ACCOUNTING_EN
    output Stats_Sel,
    input  Stats_Count,
`endif
    input  Running, Current_Proc, Offset, Resume_PC, Preempt, Done, Next_Proc, Next_Valid, Alive
  );

  modport slave (
    input  Register_Proc, Start, Proc_Index, Quantum_Load, Input_Wait, Halt_Proc, PC_In,
`ifdef SCHED_ACCOUNTING_EN
    input  Stats_Sel,
    output Stats_Count,
`endif
    output Running, Current_Proc, Offset, Resume_PC, Preempt, Done, Next_Proc, Next_Valid, Alive
  );
endinterface

// File: rtl/rr_next_alive.sv
// Round-robin pick of the next alive slot after cur, cur itself checked last.
// Latency: combinational.
// Backpressure: none; next_valid=0 and next_proc=0 when no slot is alive.
module rr_next_alive #(
  parameter int NUM_PROC = 4
) (
  input  logic [NUM_PROC-1:0]         alive,
  input  logic [$clog2(NUM_PROC)-1:0] cur,
  output logic [$clog2(NUM_PROC)-1:0] next_proc,
  output logic                        next_valid
);
  localparam int IDX_W = $clog2(NUM_PROC);

  // Scan farthest-first so the nearest alive slot after cur wins; i=NUM_PROC wraps to cur.
  always_comb begin
    next_proc = '0;
    for (int i = NUM_PROC; i >= 1; i--) begin
      if (alive[IDX_W'(cur + IDX_W'(i))]) next_proc = IDX_W'(cur + IDX_W'(i));
    end
  end

  assign next_valid = |alive;
endmodule

// File: rtl/process_scheduler.sv
// Preemptive round-robin scheduler: context table, slot base Offset, quantum timer.
// Latency: Running/Offset one cycle after Start; Preempt Q cycles after Running (+1 per stall).
// Backpressure: Input_Wait freezes the quantum; optional SCHED_ACCOUNTING_EN adds cycle counters.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PROC  = DEF_NUM_PROC,
  parameter int PC_WIDTH  = DEF_PC_WIDTH,
  parameter int Q_WIDTH   = DEF_Q_WIDTH,
  parameter int SLOT_SIZE = DEF_SLOT_SIZE
) (
  input logic Clock,
  input logic Reset,
  process_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_PROC);

  sched_state_t        state;
  logic                running;
  logic [IDX_W-1:0]    cur;
  logic [PC_WIDTH-1:0] offset;
  logic                preempt;
  logic                done;
  logic [NUM_PROC-1:0] alive;
  logic [PC_WIDTH-1:0] saved_pc [NUM_PROC];
  logic [Q_WIDTH-1:0]  qcnt;
  logic                qen;

  function automatic logic [PC_WIDTH-1:0] base_of(input logic [IDX_W-1:0] idx);
    return PC_WIDTH'(idx) * PC_WIDTH'(SLOT_SIZE);
  endfunction

  wire start_ok  = bus.Start && (alive[bus.Proc_Index] || bus.Register_Proc);
  wire q_tick    = qen && !bus.Input_Wait;
  // cur is stable through EXPIRE, so its base equals the Offset held before the transition
  wire [PC_WIDTH-1:0] rel_pc = bus.PC_In - base_of(cur);

  // Scheduler FSM with registered status outputs and the per-slot context table.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      running <= 1'b0;
      cur     <= '0;
      offset  <= '0;
      preempt <= 1'b0;
      done    <= 1'b0;
      alive   <= '0;
      qcnt    <= '0;
      qen     <= 1'b0;
      for (int i = 0; i < NUM_PROC; i++) saved_pc[i] <= '0;
    end else begin
      preempt <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Register_Proc) begin
            alive[bus.Proc_Index]    <= 1'b1;
            saved_pc[bus.Proc_Index] <= '0;
          end
          if (start_ok) begin
            state   <= RUN;
            running <= 1'b1;
            cur     <= bus.Proc_Index;
            offset  <= base_of(bus.Proc_Index);
            qcnt    <= bus.Quantum_Load;
            qen     <= (bus.Quantum_Load != '0);
          end
        end
        RUN: begin
          if (q_tick) qcnt <= qcnt - 1'b1;
          if (bus.Halt_Proc) begin
            state   <= FINISH;
            running <= 1'b0;
            offset  <= '0;
            done    <= 1'b1;
          end else if (q_tick && qcnt == Q_WIDTH'(1)) begin
            state   <= EXPIRE;
            running <= 1'b0;
            offset  <= '0;
            preempt <= 1'b1;
          end
        end
        EXPIRE: begin
          saved_pc[cur] <= rel_pc;
          state         <= IDLE;
        end
        FINISH: begin
          alive[cur]    <= 1'b0;
          saved_pc[cur] <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rr_next_alive #(.NUM_PROC(NUM_PROC)) u_next (
    .alive      (alive),
    .cur        (cur),
    .next_proc  (bus.Next_Proc),
    .next_valid (bus.Next_Valid)
  );

  assign bus.Running      = running;
  assign bus.Current_Proc = cur;
  assign bus.Offset       = offset;
  assign bus.Resume_PC    = saved_pc[cur];
  assign bus.Preempt      = preempt;
  assign bus.Done         = done;
  assign bus.Alive        = alive;

`ifdef SCHED_ACCOUNTING_EN
  logic [31:0] cycles [NUM_PROC];

  // Per-slot RUN-cycle counters, saturating; registration restarts a slot's count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PROC; i++) cycles[i] <= '0;
    end else if (state == IDLE && bus.Register_Proc) begin
      cycles[bus.Proc_Index] <= '0;
    end else if (state == RUN && cycles[cur] != '1) begin
      cycles[cur] <= cycles[cur] + 32'd1;
    end
  end

  assign bus.Stats_Count = cycles[bus.Stats_Sel];
`endif
endmodule

// File: tb/tb_process_scheduler.sv
// Directed self-checking bench for process_scheduler.
// Latency: inputs driven 1ns after the rising edge, outputs checked there too.
// Backpressure: exercises Input_Wait stalls and Quantum_Load=0.
module tb_process_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  process_scheduler_if bus ();
  process_scheduler dut (.Clock(clk), .Reset(rst), .bus(bus.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Register_Proc = 0; bus.Start = 0; bus.Proc_Index = 0; bus.Quantum_Load = 0;
    bus.Input_Wait = 0; bus.Halt_Proc = 0; bus.PC_In = 0;
`ifdef SCHED_ACCOUNTING_EN
    bus.Stats_Sel = 0;
`endif
  endtask

  task automatic do_register(input logic [1:0] idx);
    bus.Register_Proc = 1; bus.Proc_Index = idx; step(); bus.Register_Proc = 0;
  endtask

  task automatic do_start(input logic [1:0] idx, input logic [15:0] q);
    bus.Start = 1; bus.Proc_Index = idx; bus.Quantum_Load = q; step(); bus.Start = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1; step(); step();
    n_cmp++; if (bus.Running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %0b want 0", bus.Running); end
    n_cmp++; if (bus.Current_Proc !== 2'd0) begin n_fail++; $display("FAIL reset_cur got %0d want 0", bus.Current_Proc); end
    n_cmp++; if (bus.Offset !== 32'h0) begin n_fail++; $display("FAIL reset_offset got %h want 0", bus.Offset); end
    n_cmp++; if (bus.Resume_PC !== 32'h0) begin n_fail++; $display("FAIL reset_resume got %h want 0", bus.Resume_PC); end
    n_cmp++; if ({bus.Preempt, bus.Done} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {bus.Preempt, bus.Done}); end
    n_cmp++; if (bus.Alive !== 4'b0000) begin n_fail++; $display("FAIL reset_alive got %b want 0000", bus.Alive); end
    n_cmp++; if ({bus.Next_Valid, bus.Next_Proc} !== 3'b000) begin n_fail++; $display("FAIL reset_next got %b want 000", {bus.Next_Valid, bus.Next_Proc}); end
    rst = 0; step();
  endtask

  task automatic test_quantum();
    int n;
    do_register(2'd0); do_register(2'd2);
    n_cmp++; if (bus.Alive !== 4'b0101) begin n_fail++; $display("FAIL reg_alive got %b want 0101", bus.Alive); end
    bus.PC_In = 32'h205;
    do_start(2'd2, 16'd5);
    n_cmp++; if (bus.Running !== 1'b1) begin n_fail++; $display("FAIL q_running got %0b want 1", bus.Running); end
    n_cmp++; if (bus.Offset !== 32'h200) begin n_fail++; $display("FAIL q_offset got %h want 200", bus.Offset); end
    n_cmp++; if (bus.Current_Proc !== 2'd2) begin n_fail++; $display("FAIL q_cur got %0d want 2", bus.Current_Proc); end
    n_cmp++; if (bus.Resume_PC !== 32'h0) begin n_fail++; $display("FAIL q_resume0 got %h want 0", bus.Resume_PC); end
    n = 0;
    while (!bus.Preempt && n < 50) begin step(); n++; end
    n_cmp++; if (n !== 5) begin n_fail++; $display("FAIL q_preempt_delay got %0d want 5", n); end
    n_cmp++; if ({bus.Running, bus.Offset} !== 33'h0) begin n_fail++; $display("FAIL q_expire_state got run=%0b off=%h want 0/0", bus.Running, bus.Offset); end
    step();
    n_cmp++; if (bus.Resume_PC !== 32'h5) begin n_fail++; $display("FAIL q_saved_pc got %h want 5", bus.Resume_PC); end
    n_cmp++; if (bus.Preempt !== 1'b0) begin n_fail++; $display("FAIL q_preempt_pulse got %0b want 0", bus.Preempt); end
    n_cmp++; if ({bus.Next_Valid, bus.Next_Proc} !== 3'b100) begin n_fail++; $display("FAIL q_next got %b want 100", {bus.Next_Valid, bus.Next_Proc}); end
    n_cmp++; if (bus.Alive !== 4'b0101) begin n_fail++; $display("FAIL q_alive got %b want 0101", bus.Alive); end
  endtask

  task automatic test_stall();
    int n;
    bus.PC_In = 32'h205;
    do_start(2'd2, 16'd5);
    n = 0;
    while (!bus.Preempt && n < 50) begin
      bus.Input_Wait = (n >= 1 && n <= 3);
      step(); n++;
    end
    bus.Input_Wait = 0;
    n_cmp++; if (n !== 8) begin n_fail++; $display("FAIL stall_preempt_delay got %0d want 8", n); end
    step();
  endtask

  task automatic test_halt_expiry();
    do_start(2'd2, 16'd2);
    step();
    bus.Halt_Proc = 1; step(); bus.Halt_Proc = 0;
    n_cmp++; if ({bus.Done, bus.Preempt} !== 2'b10) begin n_fail++; $display("FAIL halt_pulses got done,pre=%b want 10", {bus.Done, bus.Preempt}); end
    n_cmp++; if (bus.Running !== 1'b0) begin n_fail++; $display("FAIL halt_running got %0b want 0", bus.Running); end
    step();
    n_cmp++; if (bus.Alive !== 4'b0001) begin n_fail++; $display("FAIL halt_alive got %b want 0001", bus.Alive); end
    n_cmp++; if ({bus.Next_Valid, bus.Next_Proc} !== 3'b100) begin n_fail++; $display("FAIL halt_next got %b want 100", {bus.Next_Valid, bus.Next_Proc}); end
    n_cmp++; if ({bus.Done, bus.Resume_PC} !== 33'h0) begin n_fail++; $display("FAIL halt_after got done=%0b resume=%h want 0/0", bus.Done, bus.Resume_PC); end
  endtask

  task automatic test_dead_start_and_no_quantum();
    int preempts;
    do_start(2'd1, 16'd5);
    step();
    n_cmp++; if (bus.Running !== 1'b0) begin n_fail++; $display("FAIL dead_start_running got %0b want 0", bus.Running); end
    n_cmp++; if (bus.Current_Proc !== 2'd2) begin n_fail++; $display("FAIL dead_start_cur got %0d want 2", bus.Current_Proc); end
    do_start(2'd0, 16'd0);
    preempts = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.Preempt || !bus.Running) preempts++;
      step();
    end
    n_cmp++; if (preempts !== 0) begin n_fail++; $display("FAIL q0_preempts got %0d want 0", preempts); end
    bus.Halt_Proc = 1; step(); bus.Halt_Proc = 0;
    n_cmp++; if (bus.Done !== 1'b1) begin n_fail++; $display("FAIL q0_done got %0b want 1", bus.Done); end
    step();
    n_cmp++; if ({bus.Alive, bus.Next_Valid, bus.Next_Proc} !== 7'b0000_000) begin n_fail++; $display("FAIL q0_empty got %b want 0000000", {bus.Alive, bus.Next_Valid, bus.Next_Proc}); end
  endtask

  task automatic test_back_to_back();
    bus.Register_Proc = 1; bus.Start = 1; bus.Proc_Index = 2'd3; bus.Quantum_Load = 16'd3;
    step();
    bus.Register_Proc = 0; bus.Start = 0;
    n_cmp++; if ({bus.Running, bus.Current_Proc} !== 3'b111) begin n_fail++; $display("FAIL regstart_run got %b want 111", {bus.Running, bus.Current_Proc}); end
    n_cmp++; if (bus.Offset !== 32'h300) begin n_fail++; $display("FAIL regstart_offset got %h want 300", bus.Offset); end
    bus.Halt_Proc = 1; step(); bus.Halt_Proc = 0; step();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    do_register(2'd2);
    do_start(2'd2, 16'd5);
    step(); step();
    #2 rst = 1;
    #1;
    n_cmp++; if ({bus.Running, bus.Offset, bus.Current_Proc} !== 35'h0) begin n_fail++; $display("FAIL arst_outputs got run=%0b off=%h cur=%0d want 0", bus.Running, bus.Offset, bus.Current_Proc); end
    n_cmp++; if (bus.Alive !== 4'b0000) begin n_fail++; $display("FAIL arst_alive got %b want 0000", bus.Alive); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.Preempt || bus.Done) pulses++;
      step();
    end
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.Preempt || bus.Done || bus.Running) pulses++;
      step();
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL arst_pulses got %0d want 0", pulses); end
  endtask

`ifdef SCHED_ACCOUNTING_EN
  task automatic test_accounting();
    int n;
    do_register(2'd2);
    bus.Stats_Sel = 2'd2;
    do_start(2'd2, 16'd5);
    n = 0;
    while (!bus.Preempt && n < 50) begin step(); n++; end
    step();
    n_cmp++; if (bus.Stats_Count !== 32'd5) begin n_fail++; $display("FAIL acct_count got %0d want 5", bus.Stats_Count); end
    do_register(2'd2);
    n_cmp++; if (bus.Stats_Count !== 32'd0) begin n_fail++; $display("FAIL acct_clear got %0d want 0", bus.Stats_Count); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_quantum();
    test_stall();
    test_halt_expiry();
    test_dead_start_and_no_quantum();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SCHED_ACCOUNTING_EN
    test_accounting();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
